// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal baud divider, transmit FIFO and runtime parity/stop-bit selection.
// Latency: a word accepted into an empty FIFO while idle drives the start bit (TxD=0) one edge later.
// Backpressure: tx_ready = !full; when full, offered words are ignored and queued words are never overwritten.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous active-high reset
//   tx_data, tx_valid   producer word and its valid; accepted when tx_valid && tx_ready
//   tx_ready            FIFO has room (not full)
//   parity_mode         00 none, 01 even, 10 odd, 11 none; sampled when a frame starts
//   two_stop            1 = two stop bits; sampled when a frame starts
//   TxD                 registered serial output, idle high
//   busy                frame in progress (FSM not idle)
//   tx_done             one-cycle pulse on the last cycle of a frame's final stop bit
//   fifo_count          number of queued words
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  input  logic [1:0]                       parity_mode,
  input  logic                             two_stop,
  output logic                             TxD,
  output logic                             busy,
  output logic                             tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmit FIFO: circular buffer with show-ahead head word.
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid && !fifo_full;
  assign head       = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t               state_q,    state_d;
  logic [DW-1:0]        div_q,      div_d;
  logic [BW-1:0]        bit_q,      bit_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 par_bit_q,  par_bit_d;
  logic                 par_en_q,   par_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop2_q,    stop2_d;
  logic                 txd_q,      txd_d;
  logic                 bit_end;
  logic                 load;
  logic                 done;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    load       = 1'b0;
    done       = 1'b0;

    bit_end = (div_q == DIV_LAST);

    // The divider free-runs inside a frame and restarts at every bit boundary.
    if (bit_end) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        txd_d = 1'b1;
        load  = !fifo_empty;
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end

      // shift_q[0] is always the bit currently on the line.
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d = S_STOP;
              stop2_d = 1'b0;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop2_d = 1'b0;
          txd_d   = 1'b1;
        end
      end

      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            done = 1'b1;
            // Chain straight into the next frame when a word is waiting.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    // Frame launch: pop the head word and freeze the line configuration so
    // mid-frame changes only affect the following frame.
    if (load) begin
      pop        = 1'b1;
      state_d    = S_START;
      div_d      = '0;
      shift_d    = head;
      par_bit_d  = (^head) ^ (parity_mode == 2'b10);
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      two_stop_d = two_stop;
      txd_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
    end
  end

  assign TxD        = txd_q;
  assign busy       = (state_q != S_IDLE);
  assign tx_done    = done;
  assign tx_ready   = !fifo_full;
  assign fifo_count = count_q;

endmodule
